// File: rtl/enigma_implementation_return.sv
// Enigma return path: reflected letter -> rotor2^-1 -> rotor1^-1 -> rotor0^-1, 3-stage valid/ready pipe.
// Optional RETURN_ERR_EN: codes >25 pass through unmapped and flagged instead of being dropped.
module enigma_implementation_return #(
  parameter int unsigned LW          = 5,
  parameter int unsigned NUM_LETTERS = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [LW-1:0] in_letter,
  input  logic [LW-1:0] r1_position,
  input  logic [LW-1:0] r2_position,
  input  logic [LW-1:0] r3_position,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] out_letter,
  output logic          out_err
);

  localparam int unsigned SW = LW + 1;

  localparam logic [LW-1:0] INV0 [NUM_LETTERS] = '{
    5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25, 5'd1,  5'd4,  5'd2,
    5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11, 5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9};
  localparam logic [LW-1:0] INV1 [NUM_LETTERS] = '{
    5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,  5'd3,  5'd10, 5'd14,
    5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13, 5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18};
  localparam logic [LW-1:0] INV2 [NUM_LETTERS] = '{
    5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,  5'd20, 5'd5,  5'd21,
    5'd13, 5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,  5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};

  // Single conditional subtract: every caller keeps v below 2*NUM_LETTERS.
  function automatic logic [LW-1:0] wrap(input logic [SW-1:0] v);
    return (v >= SW'(NUM_LETTERS)) ? LW'(v - SW'(NUM_LETTERS)) : LW'(v);
  endfunction

  function automatic logic [LW-1:0] unshift(input logic [LW-1:0] w, input logic [LW-1:0] p);
    return wrap(SW'(w) + SW'(NUM_LETTERS) - SW'(p));
  endfunction

  logic          s0_valid, s1_valid;
  logic [LW-1:0] s0_letter, s1_letter;
  logic [LW-1:0] s0_p1, s0_p2, s1_p1;
  logic          s0_err, s1_err;
  logic          code_bad_c, keep_c;
  logic          out_free_c, s1_free_c, s0_adv_c, s1_adv_c;
  logic [LW-1:0] idx2_c, idx1_c, idx0_c, map2_c, map1_c, map0_c;

  // Backpressure chain: a stage moves when the one after it is empty or moving.
  assign out_free_c = !out_valid || out_ready;
  assign s1_free_c  = !s1_valid || out_free_c;
  assign s1_adv_c   = s1_valid && out_free_c;
  assign s0_adv_c   = s0_valid && s1_free_c;
  assign in_ready   = !s0_valid || s1_free_c;

  assign code_bad_c = in_letter > LW'(NUM_LETTERS - 1);

  assign idx2_c = wrap(SW'(in_letter) + SW'(r3_position));
  assign map2_c = unshift(INV2[idx2_c], r3_position);
  assign idx1_c = wrap(SW'(s0_letter) + SW'(s0_p2));
  assign map1_c = unshift(INV1[idx1_c], s0_p2);
  assign idx0_c = wrap(SW'(s1_letter) + SW'(s1_p1));
  assign map0_c = unshift(INV0[idx0_c], s1_p1);

`ifdef RETURN_ERR_EN
  assign keep_c = 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_err  <= 1'b0;
      s1_err  <= 1'b0;
      out_err <= 1'b0;
    end else begin
      if (in_valid && in_ready) s0_err  <= code_bad_c;
      if (s0_adv_c)             s1_err  <= s0_err;
      if (s1_adv_c)             out_err <= s1_err;
    end
  end
`else
  assign keep_c  = !code_bad_c;
  assign s0_err  = 1'b0;
  assign s1_err  = 1'b0;
  assign out_err = 1'b0;
`endif

  // Positions ride along with the letter so the forward path may step freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_valid   <= 1'b0;
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      s0_letter  <= '0;
      s1_letter  <= '0;
      out_letter <= '0;
      s0_p1      <= '0;
      s0_p2      <= '0;
      s1_p1      <= '0;
    end else begin
      if (in_ready) s0_valid <= in_valid && keep_c;
      if (in_valid && in_ready) begin
        s0_letter <= code_bad_c ? in_letter : map2_c;
        s0_p1     <= r1_position;
        s0_p2     <= r2_position;
      end
      if (s1_free_c) s1_valid <= s0_valid;
      if (s0_adv_c) begin
        s1_letter <= s0_err ? s0_letter : map1_c;
        s1_p1     <= s0_p1;
      end
      if (out_free_c) out_valid <= s1_valid;
      if (s1_adv_c) out_letter <= s1_err ? s1_letter : map0_c;
    end
  end

endmodule

// File: tb/tb_enigma_implementation_return.sv
// Bench for enigma_implementation_return: string-based Enigma model + scoreboard, directed vectors.
module tb_enigma_implementation_return;

`ifdef RETURN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_err;
  logic [4:0] in_letter, r1_position, r2_position, r3_position, out_letter;

  int n_tests = 0;
  int n_fail  = 0;
  int pop_cnt = 0;
  logic [5:0] sb[$];
  logic       hold_prev = 1'b0;
  logic [5:0] held;

  enigma_implementation_return dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_letter(in_letter),
    .r1_position(r1_position), .r2_position(r2_position), .r3_position(r3_position),
    .out_valid(out_valid), .out_ready(out_ready), .out_letter(out_letter), .out_err(out_err));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inverse rotor found by searching the forward wiring, not by a table.
  function automatic int back_through(input string w, input int c, input int p);
    int e, k;
    e = (c + p) % 26;
    k = 0;
    for (int j = 0; j < 26; j++) if (int'(w[j]) - 65 == e) k = j;
    return (k - p + 26) % 26;
  endfunction

  function automatic logic [5:0] model(input int l, input int p1, input int p2, input int p3);
    int a, b, c;
    if (l > 25) return {1'b1, 5'(l)};
    a = back_through("BDFHJLCPRTXVZNYEIWGAKMUSQO", l, p3);
    b = back_through("AJDKSIRUXBLHWTMCQGZNPYFVOE", a, p2);
    c = back_through("EKMFLGDQVZNTOWYHXUSPAIBRCJ", b, p1);
    return {1'b0, 5'(c)};
  endfunction

  // Scoreboard / stability monitor.
  always @(negedge clk) begin
    logic [5:0] e;
    if (!rst) begin
      hold_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        e = model(int'(in_letter), int'(r1_position), int'(r2_position), int'(r3_position));
        if (ERR_EN || !e[5]) sb.push_back(e);
      end
      if (hold_prev) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'({out_err, out_letter}), int'(held));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("stale_output", int'(out_letter), -1);
        else begin
          e = sb.pop_front();
          check("sb_letter_err", int'({out_err, out_letter}), int'(e));
        end
        pop_cnt++;
      end
      hold_prev = out_valid && !out_ready;
      held      = {out_err, out_letter};
    end
  end

  task automatic send(input int l, input int p1, input int p2, input int p3);
    logic acc;
    int   n;
    in_valid = 1'b1; in_letter = 5'(l);
    r1_position = 5'(p1); r2_position = 5'(p2); r3_position = 5'(p3);
    n = 0;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Called #1 after the accepting edge; counts edges from accept to out_valid.
  task automatic wait_out(input string name, input int exp_letter, input int exp_err);
    int lat;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_letter"}, int'(out_letter), exp_letter);
    check({name, "_err"}, int'(out_err), exp_err);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    check("drain", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_letter = '0;
    r1_position = '0; r2_position = '0; r3_position = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_letter", int'(out_letter), 0);
    check("reset_out_err", int'(out_err), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Model pins against hand-traced values.
    check("model_A_000", int'(model(0, 0, 0, 0)), 10);
    check("model_A_001", int'(model(0, 0, 0, 1)), 18);

    send(0, 0, 0, 0);
    wait_out("pos000_A", 10, 0);
    drain();
    send(0, 0, 0, 1);
    wait_out("wrap_r3_A", 18, 0);
    drain();

    // Full alphabet back-to-back; no bubbles allowed.
    base = pop_cnt;
    for (int i = 0; i < 26; i++) send(i, 5, 17, 25);
    repeat (3) @(posedge clk);
    #1;
    check("stream_count", pop_cnt - base, 26);
    drain();

    // Backpressure: capacity 3, in_ready returns with out_ready.
    out_ready = 1'b0;
    send(3, 1, 2, 3);
    send(4, 1, 2, 3);
    send(5, 1, 2, 3);
    in_valid = 1'b1; in_letter = 5'd6;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_in_ready_low", int'(in_ready), 0);
    check("bp_out_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_return", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(7, 1, 2, 3);
    drain();

    // Invalid code 30.
    send(30, 0, 0, 0);
    if (ERR_EN) begin
      wait_out("bad_code", 30, 1);
      drain();
      send(0, 0, 0, 0);
    end else begin
      send(0, 0, 0, 0);
    end
    wait_out("after_bad", 10, 0);
    drain();

    // Reset with two letters in flight.
    send(1, 2, 3, 4);
    send(2, 2, 3, 4);
    #2;
    rst = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_no_stale", int'(out_valid), 0);
    send(0, 0, 0, 0);
    wait_out("post_rst", 10, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
